// File: rtl/tex_gate_pkg.sv
// Shared types and constants for the texture issue gate: request payload layout and FSM states.
package tex_gate_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned NTEX_BITS   = 1;
  localparam int unsigned UUID_BITS   = 44;
  localparam int unsigned CSR_ADDR_W  = 12;
  localparam int unsigned CSR_DATA_W  = 32;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StWrite
  } gate_state_t;

  typedef struct packed {
    logic [NTEX_BITS-1:0]               unit;
    logic [NUM_THREADS-1:0]             tmask;
    logic [NUM_THREADS-1:0][1:0][31:0]  coords;
    logic [NUM_THREADS-1:0][31:0]       lod;
    logic [4:0]                         rd;
    logic                               wb;
    logic [NW_BITS-1:0]                 wid;
    logic [31:0]                        pc;
    logic [UUID_BITS-1:0]               uuid;
  } tex_req_t;

  localparam int unsigned REQ_W   = $bits(tex_req_t);
  // wid sits directly above {pc, uuid} in the packed payload.
  localparam int unsigned WID_LSB = UUID_BITS + 32;

endpackage

// File: rtl/tex_gate_fifo.sv
// Registered request FIFO; an entry written in cycle N is readable from cycle N+1.
module tex_gate_fifo
  import tex_gate_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [REQ_W-1:0] data_i,
  input  logic             pop_i,
  output logic [REQ_W-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PW   = PtrW + 1;

  tex_req_t      mem_q [Depth];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= tex_req_t'(data_i);
    end
  end

  assign data_o = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/tex_issue_gate.sv
// Buffers texture requests, caps requests in flight, tracks per-warp outstanding work and
// serialises texture CSR writes behind every in-flight request.
module tex_issue_gate
  import tex_gate_pkg::*;
#(
  parameter int unsigned QueueDepth  = 2,
  parameter int unsigned MaxInflight = 8,
  localparam int unsigned CntW       = $clog2(MaxInflight + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [REQ_W-1:0]      in_payload_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [REQ_W-1:0]      out_payload_o,
  input  logic                  rsp_fire_i,
  input  logic [NW_BITS-1:0]    rsp_wid_i,
  input  logic                  csr_in_valid_i,
  output logic                  csr_in_ready_o,
  input  logic [CSR_ADDR_W-1:0] csr_in_addr_i,
  input  logic [CSR_DATA_W-1:0] csr_in_data_i,
  output logic                  csr_out_we_o,
  output logic [CSR_ADDR_W-1:0] csr_out_addr_o,
  output logic [CSR_DATA_W-1:0] csr_out_data_o,
  output logic [NUM_WARPS-1:0]  warp_pending_o,
  output logic [CntW-1:0]       inflight_cnt_o,
  output logic                  err_underflow_o
);

  localparam int unsigned WCntW = $clog2(QueueDepth + MaxInflight + 1);

  gate_state_t                      state_q, state_d;
  logic [CntW-1:0]                  inflight_q, inflight_d;
  logic [NUM_WARPS-1:0][WCntW-1:0]  wcnt_q, wcnt_d;
  logic                             err_q, err_d;
  logic [CSR_ADDR_W-1:0]            csr_addr_q, csr_addr_d;
  logic [CSR_DATA_W-1:0]            csr_data_q, csr_data_d;

  logic                             fifo_full, fifo_empty;
  logic                             in_fire, out_fire;
  logic [NW_BITS-1:0]               in_wid;
  logic [NUM_WARPS-1:0]             warp_inc, warp_dec;

  assign in_wid = in_payload_i[WID_LSB +: NW_BITS];

  assign in_ready_o  = (state_q == StRun) && !fifo_full && !csr_in_valid_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = !fifo_empty && (inflight_q < CntW'(MaxInflight));
  assign out_fire    = out_valid_o && out_ready_i;

  tex_gate_fifo #(
    .Depth (QueueDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_fire),
    .data_i  (in_payload_i),
    .pop_i   (out_fire),
    .data_o  (out_payload_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    warp_inc = '0;
    warp_dec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_inc[w] = in_fire && (in_wid == NW_BITS'(w));
      warp_dec[w] = rsp_fire_i && (rsp_wid_i == NW_BITS'(w));
    end
  end

  // A response against an empty counter is dropped and flagged; the counter never wraps.
  always_comb begin
    err_d      = err_q;
    inflight_d = inflight_q;
    wcnt_d     = wcnt_q;
    if (rsp_fire_i && (inflight_q == '0)) begin
      err_d      = 1'b1;
      inflight_d = inflight_q + CntW'(out_fire);
    end else begin
      inflight_d = inflight_q + CntW'(out_fire) - CntW'(rsp_fire_i);
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (warp_dec[w] && (wcnt_q[w] == '0)) begin
        err_d     = 1'b1;
        wcnt_d[w] = wcnt_q[w] + WCntW'(warp_inc[w]);
      end else begin
        wcnt_d[w] = wcnt_q[w] + WCntW'(warp_inc[w]) - WCntW'(warp_dec[w]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    csr_addr_d = csr_addr_q;
    csr_data_d = csr_data_q;
    unique case (state_q)
      StRun: begin
        if (csr_in_valid_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Looking at the next count lets a same-cycle response complete the drain.
        if (!csr_in_valid_i) begin
          state_d = StRun;
        end else if (fifo_empty && (inflight_d == '0)) begin
          csr_addr_d = csr_in_addr_i;
          csr_data_d = csr_in_data_i;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      inflight_q <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
    end
  end

  always_comb begin
    warp_pending_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_pending_o[w] = |wcnt_q[w];
    end
  end

  assign csr_out_we_o    = (state_q == StWrite);
  assign csr_in_ready_o  = (state_q == StWrite);
  assign csr_out_addr_o  = csr_addr_q;
  assign csr_out_data_o  = csr_data_q;
  assign inflight_cnt_o  = inflight_q;
  assign err_underflow_o = err_q;

endmodule
